// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use detection, multi-cycle MUL/DIV sequencing,
// data-memory freeze, branch-flush priority and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int MULDIV_LATENCY = 32,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [REG_ADDR_WIDTH-1:0]         REG_WRITE_ADDR_EX,
    input  logic                              MEM_READ_EN_EX,
    input  logic                              MULDIV_START_EX,
    input  logic                              BRANCH_TAKEN_EX,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ADDR_ID,
    input  logic [NUM_SRC-1:0]                USE_REG_ID,
    input  logic                              DMEM_BUSY,
    output logic                              STALL_PC,
    output logic                              STALL_IF_ID,
    output logic                              STALL_ID_EX,
    output logic                              STALL_EX_MEM,
    output logic                              BUBBLE_ID_EX,
    output logic                              FLUSH_IF_ID,
    output logic                              LU_HAZARD,
    output logic                              MULDIV_BUSY,
    output logic [COUNT_WIDTH-1:0]            STALL_CYCLES
);

    localparam int CNT_W = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lu_match;

    always_comb begin
        lu_match = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (USE_REG_ID[i] && (ADDR_ID[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_WRITE_ADDR_EX))
                lu_match = 1'b1;
        end
        lu_match = lu_match && MEM_READ_EN_EX && (REG_WRITE_ADDR_EX != '0);
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        STALL_PC     = 1'b0;
        STALL_IF_ID  = 1'b0;
        STALL_ID_EX  = 1'b0;
        STALL_EX_MEM = 1'b0;
        BUBBLE_ID_EX = 1'b0;
        FLUSH_IF_ID  = 1'b0;
        LU_HAZARD    = 1'b0;
        MULDIV_BUSY  = (state == WAIT);

        if (DMEM_BUSY) begin
            STALL_PC     = 1'b1;
            STALL_IF_ID  = 1'b1;
            STALL_ID_EX  = 1'b1;
            STALL_EX_MEM = 1'b1;
        end else if (state == WAIT) begin
            if (cnt != '0) begin
                STALL_PC    = 1'b1;
                STALL_IF_ID = 1'b1;
                STALL_ID_EX = 1'b1;
                cnt_next    = cnt - 1'b1;
            end else begin
                state_next = IDLE;
            end
        end else if (MULDIV_START_EX && (MULDIV_LATENCY >= 2)) begin
            // First EX cycle is this one; WAIT covers the remaining LATENCY-1 cycles.
            STALL_PC    = 1'b1;
            STALL_IF_ID = 1'b1;
            STALL_ID_EX = 1'b1;
            cnt_next    = CNT_W'(MULDIV_LATENCY - 2);
            state_next  = WAIT;
        end else if (BRANCH_TAKEN_EX) begin
            FLUSH_IF_ID  = 1'b1;
            BUBBLE_ID_EX = 1'b1;
        end else if (lu_match) begin
            LU_HAZARD    = 1'b1;
            STALL_PC     = 1'b1;
            STALL_IF_ID  = 1'b1;
            BUBBLE_ID_EX = 1'b1;
        end

        // Outputs must read 0 for the whole reset interval, not just after the edge.
        if (RESET) begin
            STALL_PC     = 1'b0;
            STALL_IF_ID  = 1'b0;
            STALL_ID_EX  = 1'b0;
            STALL_EX_MEM = 1'b0;
            BUBBLE_ID_EX = 1'b0;
            FLUSH_IF_ID  = 1'b0;
            LU_HAZARD    = 1'b0;
            MULDIV_BUSY  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_CYCLES <= '0;
        end else if (STALL_PC && (STALL_CYCLES != '1)) begin
            STALL_CYCLES <= STALL_CYCLES + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: driver pushes model expectations,
// a separate monitor pops and compares them against the DUT outputs.
module tb_hazard_control_unit;

    localparam int W  = 5;
    localparam int N  = 3;
    localparam int L  = 4;
    localparam int CW = 3;
    localparam int OW = 8 + CW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    wa = '0;
    logic            mr = 1'b0, md = 1'b0, br = 1'b0, busy = 1'b0;
    logic [N*W-1:0]  addr = '0;
    logic [N-1:0]    uses = '0;

    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic bubble_id_ex, flush_if_id, lu_hazard, muldiv_busy;
    logic [CW-1:0] stall_cycles;

    hazard_control_unit #(
        .REG_ADDR_WIDTH(W),
        .NUM_SRC(N),
        .MULDIV_LATENCY(L),
        .COUNT_WIDTH(CW)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .REG_WRITE_ADDR_EX(wa),
        .MEM_READ_EN_EX(mr),
        .MULDIV_START_EX(md),
        .BRANCH_TAKEN_EX(br),
        .ADDR_ID(addr),
        .USE_REG_ID(uses),
        .DMEM_BUSY(busy),
        .STALL_PC(stall_pc),
        .STALL_IF_ID(stall_if_id),
        .STALL_ID_EX(stall_id_ex),
        .STALL_EX_MEM(stall_ex_mem),
        .BUBBLE_ID_EX(bubble_id_ex),
        .FLUSH_IF_ID(flush_if_id),
        .LU_HAZARD(lu_hazard),
        .MULDIV_BUSY(muldiv_busy),
        .STALL_CYCLES(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OW-1:0] val;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    // Model: cycles of EX residency still owed by the current MUL/DIV, and stall count.
    int m_left  = 0;
    int m_count = 0;

    task automatic drive(input string name, input logic r, input logic [W-1:0] dst,
                         input logic ld, input logic mul, input logic brn,
                         input logic [N*W-1:0] a, input logic [N-1:0] u, input logic b);
        logic lu, spc, sif, sid, sem, bub, fl, luo, mb;
        exp_t e;
        @(negedge clk);
        rst = r; wa = dst; mr = ld; md = mul; br = brn; addr = a; uses = u; busy = b;
        {spc, sif, sid, sem, bub, fl, luo, mb} = '0;
        if (r) begin
            m_left  = 0;
            m_count = 0;
            e.val   = '0;
        end else begin
            lu = 1'b0;
            if (ld && dst != 0)
                for (int i = 0; i < N; i++)
                    if (u[i] && a[i*W +: W] == dst) lu = 1'b1;
            mb = (m_left > 0);
            if (b) begin
                {spc, sif, sid, sem} = 4'b1111;
            end else if (m_left > 0) begin
                if (m_left > 1) {spc, sif, sid} = 3'b111;
                m_left = m_left - 1;
            end else if (mul) begin
                {spc, sif, sid} = 3'b111;
                m_left = L - 1;
            end else if (brn) begin
                fl  = 1'b1;
                bub = 1'b1;
            end else if (lu) begin
                {luo, spc, sif, bub} = 4'b1111;
            end
            e.val = {spc, sif, sid, sem, bub, fl, luo, mb, CW'(m_count)};
            if (spc && m_count < (1 << CW) - 1) m_count = m_count + 1;
        end
        e.name = name;
        exp_q.push_back(e);
        ->sample_ev;
    endtask

    function automatic logic [N*W-1:0] pack3(input int a0, input int a1, input int a2);
        return {W'(a2), W'(a1), W'(a0)};
    endfunction

    initial begin : monitor
        exp_t e;
        logic [OW-1:0] act;
        forever begin
            @(sample_ev);
            #2;
            act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_id_ex,
                   flush_if_id, lu_hazard, muldiv_busy, stall_cycles};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=%b", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s actual=%b required=%b (pc,ifid,idex,exmem,bub,flush,lu,busy,cnt)",
                             e.name, act, e.val);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N*W-1:0] ra;
        drive("reset0", 1, 5'd5, 1, 1, 1, pack3(5, 5, 5), '1, 1);
        drive("reset1", 1, 0, 0, 0, 0, '0, '0, 0);

        drive("lu_op1",      0, 5'd5, 1, 0, 0, pack3(0, 5, 0), 3'b010, 0);
        drive("lu_unused",   0, 5'd5, 1, 0, 0, pack3(0, 5, 0), 3'b000, 0);
        drive("lu_dest_x0",  0, 5'd0, 1, 0, 0, pack3(0, 0, 0), 3'b111, 0);
        drive("lu_not_load", 0, 5'd5, 0, 0, 0, pack3(5, 5, 5), 3'b111, 0);
        drive("lu_op2",      0, 5'd9, 1, 0, 0, pack3(1, 2, 9), 3'b111, 0);
        drive("lu_nomatch",  0, 5'd9, 1, 0, 0, pack3(1, 2, 3), 3'b111, 0);

        for (int i = 0; i < 4; i++) drive("muldiv", 0, 0, 0, 1, 0, '0, '0, 0);
        drive("muldiv_after", 0, 0, 0, 0, 0, '0, '0, 0);

        drive("md_busy", 0, 0, 0, 1, 0, '0, '0, 0);
        drive("md_busy", 0, 0, 0, 1, 0, '0, '0, 1);
        drive("md_busy", 0, 0, 0, 1, 0, '0, '0, 1);
        for (int i = 0; i < 3; i++) drive("md_busy", 0, 0, 0, 1, 0, '0, '0, 0);
        drive("md_busy_after", 0, 0, 0, 0, 0, '0, '0, 0);

        drive("branch_vs_lu", 0, 5'd7, 1, 0, 1, pack3(7, 0, 0), 3'b001, 0);

        drive("wait_enter",  0, 0, 0, 1, 0, '0, '0, 0);
        drive("reset_wait",  1, 0, 0, 1, 0, '0, '0, 0);
        drive("post_reset",  0, 5'd3, 1, 0, 0, pack3(3, 0, 0), 3'b001, 0);

        for (int i = 0; i < 12; i++) drive("sat", 0, 0, 0, 0, 0, '0, '0, 1);

        drive("reset2", 1, 0, 0, 0, 0, '0, '0, 0);
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) ra[i*W +: W] = W'($urandom_range(0, 7));
            drive("random",
                  ($urandom_range(0, 99) < 2),
                  W'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 20),
                  ra,
                  N'($urandom),
                  ($urandom_range(0, 99) < 15));
        end

        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
